// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with synchronizer and debounce
//
// Walks a single low column across the keypad, samples the active-low rows
// after each dwell period, debounces a single-key press and its release, and
// reports one hex key code per accepted press.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low
//   rows       keypad rows, asynchronous, active-low (bit r = row r)
//   cols       column drive, active-low, one bit low at a time (bit c = column c)
//   key_code   hex code of the last accepted key
//   key_valid  one-cycle pulse on each accepted press
//   key_held   high from acceptance until the debounced release

module keypad_scanner #(
  parameter int SCAN_DIV        = 24000,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      row_q, row_d;
  logic [3:0]      pat_q, pat_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  logic [3:0]      sync1_q, rows_s_q;

  logic            one_low;
  logic [1:0]      row_enc;
  logic            row_bit;

  // Row-major keypad legend; * and # are reported as E and F.
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Exactly one row low identifies a single key; anything else is ambiguous.
  always_comb begin
    one_low = 1'b1;
    row_enc = 2'd0;
    case (rows_s_q)
      4'b1110: row_enc = 2'd0;
      4'b1101: row_enc = 2'd1;
      4'b1011: row_enc = 2'd2;
      4'b0111: row_enc = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign row_bit = rows_s_q[row_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    pat_d   = pat_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    case (state_q)
      S_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          if (one_low) begin
            row_d   = row_enc;
            pat_d   = rows_s_q;
            cnt_d   = '0;
            state_d = S_DEBOUNCE;
          end else begin
            idx_d   = idx_q + 2'd1;
            dwell_d = '0;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      S_DEBOUNCE: begin
        if (cnt_q == CNT_MAX) begin
          code_d  = map_key(row_q, idx_q);
          valid_d = 1'b1;
          held_d  = 1'b1;
          state_d = S_HELD;
        end else if (rows_s_q == pat_q) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          // Bounce: give up on this column and keep scanning.
          state_d = S_SCAN;
          idx_d   = idx_q + 2'd1;
          dwell_d = '0;
        end
      end
      S_HELD: begin
        // Only the latched row matters; other keys in this column are ignored.
        if (row_bit) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!row_bit) begin
          state_d = S_HELD;
        end else if (cnt_q == CNT_MAX) begin
          held_d  = 1'b0;
          state_d = S_SCAN;
          idx_d   = 2'd0;
          dwell_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_SCAN;
      idx_q    <= 2'd0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      row_q    <= 2'd0;
      pat_q    <= 4'b1111;
      code_q   <= 4'h0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
      sync1_q  <= 4'b1111;
      rows_s_q <= 4'b1111;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      pat_q    <= pat_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
      sync1_q  <= rows;
      rows_s_q <= sync1_q;
    end
  end

  // The column index holds outside SCAN, so it doubles as the latched column.
  assign cols      = ~(4'b0001 << idx_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
